// File: rtl/tone_gen.sv
// Square-wave tone generator: half-period = note x PRESCALE clocks, note changes land on half-period boundaries.
// Optional TONE_GEN_OCTAVE_EN adds octave[1:0], dividing the prescale period by 2^octave.
module tone_gen #(
  parameter int PRESCALE = 1000,
  parameter int NOTE_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NOTE_W-1:0] note,
`ifdef TONE_GEN_OCTAVE_EN
  input  logic [1:0]        octave,
`endif
  output logic              audio_out,
  output logic              active,
  output logic              edge_pulse
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] TERM_MAX = PW'(PRESCALE - 1);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     pre_cnt;
  logic [PW-1:0]     term;
  logic [NOTE_W-1:0] hp_cnt;
  logic [NOTE_W-1:0] cur_note;
  logic              tick;
  logic              hp_last;
  logic              boundary;

`ifdef TONE_GEN_OCTAVE_EN
  logic [1:0] cur_oct;
  // PRESCALE is a multiple of 8, so (PRESCALE-1)>>k == (PRESCALE>>k)-1
  assign term = TERM_MAX >> cur_oct;
`else
  assign term = TERM_MAX;
`endif

  assign tick     = (pre_cnt == term);
  assign hp_last  = (hp_cnt == cur_note - NOTE_W'(1));
  assign boundary = (state == PLAY) && tick && hp_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (note != '0) state_nxt = PLAY;
      PLAY:    if (boundary && note == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    active = (state == PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt    <= '0;
      hp_cnt     <= '0;
      cur_note   <= '0;
      audio_out  <= 1'b0;
      edge_pulse <= 1'b0;
`ifdef TONE_GEN_OCTAVE_EN
      cur_oct    <= 2'd0;
`endif
    end else begin
      edge_pulse <= 1'b0;
      if (state == IDLE) begin
        pre_cnt   <= '0;
        hp_cnt    <= '0;
        audio_out <= 1'b0;
        if (note != '0) begin
          cur_note <= note;
`ifdef TONE_GEN_OCTAVE_EN
          cur_oct  <= octave;
`endif
        end
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
        if (tick) begin
          if (hp_last) begin
            // boundary: resample the request; a zero note ends play with audio parked low
            hp_cnt   <= '0;
            cur_note <= note;
`ifdef TONE_GEN_OCTAVE_EN
            cur_oct  <= octave;
`endif
            if (note != '0) begin
              audio_out  <= ~audio_out;
              edge_pulse <= 1'b1;
            end else begin
              audio_out  <= 1'b0;
              edge_pulse <= audio_out;
            end
          end else begin
            hp_cnt <= hp_cnt + NOTE_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// Directed + randomized bench for tone_gen against a countdown-based reference model.
module tb_tone_gen;
`ifdef TONE_GEN_OCTAVE_EN
  localparam int P = 8;
`else
  localparam int P = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] note = '0;
  logic       audio_out, active, edge_pulse;
  int         oct_in = 0;
`ifdef TONE_GEN_OCTAVE_EN
  wire [1:0]  octave = oct_in[1:0];
`endif

  tone_gen #(.PRESCALE(P), .NOTE_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note       (note),
`ifdef TONE_GEN_OCTAVE_EN
    .octave     (octave),
`endif
    .audio_out  (audio_out),
    .active     (active),
    .edge_pulse (edge_pulse)
  );

  always #5 clk = ~clk;

  // reference model: cycles remaining in the current half-period
  bit         m_active, m_audio, m_edge;
  int         m_rem;
  int         cyc_n = 0;
  int         total = 0;
  int         fails = 0;
  logic [5:0] cur = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_audio = 0; m_edge = 0; m_rem = 0;
  endtask

  task automatic model_step(input logic [5:0] n, input int oct);
    m_edge = 0;
    if (!m_active) begin
      if (n != 0) begin
        m_active = 1; m_audio = 0; m_rem = int'(n) * (P >> oct);
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        if (n != 0) begin
          m_audio = !m_audio; m_edge = 1; m_rem = int'(n) * (P >> oct);
        end else begin
          m_edge = m_audio; m_audio = 0; m_active = 0;
        end
      end
    end
  endtask

  task automatic cyc(input logic [5:0] n);
    @(negedge clk);
    note = n;
    @(posedge clk);
    model_step(n, oct_in);
    #1;
    cyc_n++;
    check("outputs{audio,active,edge}", {29'd0, audio_out, active, edge_pulse},
          {29'd0, m_audio, m_active, m_edge});
  endtask

  // 0: active high, 1: audio high, 2: edge pulse, 3: audio low, 4: active low
  task automatic run_until(input int what, input int limit, input string tag, output int t);
    bit hit;
    hit = 0;
    t = -1;
    for (int i = 0; i < limit && !hit; i++) begin
      cyc(cur);
      case (what)
        0:       hit = active;
        1:       hit = audio_out;
        2:       hit = edge_pulse;
        3:       hit = !audio_out;
        default: hit = !active;
      endcase
    end
    check({tag, " reached"}, {31'd0, hit}, 32'd1);
    if (hit) t = cyc_n;
  endtask

  task automatic run(input int ncyc);
    for (int i = 0; i < ncyc; i++) cyc(cur);
  endtask

  initial begin
    int ta, tr, tf, t1, t2;
    model_reset();
    #12;
    check("reset outputs", {29'd0, audio_out, active, edge_pulse}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // held note: first rise and every half-period at 38*P
    cur = 6'd38;
    run_until(0, 5, "t1 active", ta);
    run_until(1, 38*P + 5, "t1 rise", tr);
    check("t1 first rise delay", tr - ta, 38*P);
    run_until(2, 38*P + 5, "t1 fall", tf);
    check("t1 half period", tf - tr, 38*P);
    check("t1 audio low after fall", {31'd0, audio_out}, 32'd0);
    cyc(cur);
    check("t1 pulse one cycle", {31'd0, edge_pulse}, 32'd0);

    // mid-period note change only takes effect at the boundary
    run(60);
    cur = 6'd20;
    run_until(2, 38*P + 5, "t2 boundary", t1);
    check("t2 current period kept", t1 - tf, 38*P);
    run_until(2, 20*P + 5, "t2 next", t2);
    check("t2 new half period", t2 - t1, 20*P);

    // stop while audio is high: falling edge pulse and drop to idle at the boundary
    cur = 6'd30;
    run_until(2, 20*P + 5, "t3 switch", t1);
    if (!audio_out) run_until(2, 30*P + 5, "t3 to high", t1);
    check("t3 audio high before stop", {31'd0, audio_out}, 32'd1);
    run(7);
    cur = 6'd0;
    run_until(2, 30*P + 5, "t3 stop edge", t2);
    check("t3 stop at boundary", t2 - t1, 30*P);
    check("t3 audio low", {31'd0, audio_out}, 32'd0);
    check("t3 inactive", {31'd0, active}, 32'd0);
    run(50);
    check("t3 stays idle", {30'd0, active, audio_out}, 32'd0);

    // zero glitch between boundaries is ignored
    cur = 6'd30;
    run_until(0, 5, "t4 active", ta);
    run(20);
    cur = 6'd0;
    run(10);
    cur = 6'd30;
    run_until(1, 30*P + 5, "t4 rise", tr);
    check("t4 first rise unchanged", tr - ta, 30*P);
    run_until(2, 30*P + 5, "t4 fall", tf);
    check("t4 half period", tf - tr, 30*P);

    // asynchronous reset while audio is high
    run_until(1, 30*P + 5, "t5 high", t1);
    run(10);
    #2 rst_n = 1'b0;
    #1;
    check("t5 async reset outputs", {29'd0, audio_out, active, edge_pulse}, 32'd0);
    model_reset();
    cur = 6'd0;
    note = 6'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t5 held in reset", {29'd0, audio_out, active, edge_pulse}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cur = 6'd36;
    run_until(0, 5, "t5 active", ta);
    run_until(1, 36*P + 5, "t5 rise", tr);
    check("t5 first rise after reset", tr - ta, 36*P);

`ifdef TONE_GEN_OCTAVE_EN
    // octave raises pitch, sampled at boundaries only
    cur = 6'd0;
    run_until(4, 40*P, "t6 idle", t1);
    oct_in = 2;
    cur = 6'd10;
    run_until(0, 5, "t6 active", ta);
    run_until(1, 10*P + 5, "t6 rise", tr);
    check("t6 octave2 half period", tr - ta, 20);
    run(5);
    oct_in = 0;
    run_until(2, 10*P + 5, "t6 fall", tf);
    check("t6 octave kept mid period", tf - tr, 20);
    run_until(2, 10*P + 5, "t6 next", t2);
    check("t6 octave0 half period", t2 - tf, 80);
`endif

    // randomized note traffic with zero glitches
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        cur = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 12));
`ifdef TONE_GEN_OCTAVE_EN
        oct_in = int'($urandom_range(0, 3));
`endif
      end
      if ($urandom_range(0, 59) == 0) cyc(6'd0);
      else cyc(cur);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
